// File: rtl/serializer_pkg.sv
// Shared constants, state encoding and length decode for the serializer.
package serializer_pkg;

  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W);
  localparam int LEN_W  = MOD_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // A bit count of 0 encodes a full word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [MOD_W-1:0] mod);
    if (mod == '0) return LEN_W'(DATA_W);
    return {1'b0, mod};
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial stage, LSB first, feeding the 16-bit deserializer.
// SERIALIZER_ZERO_PAD_EN: pad short words with zeros to a full DATA_W frame.
module serializer
  import serializer_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(3);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  last_idx;
  logic              last_bit;
  logic              accept;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    len_in = eff_len(data_mod_i);
`ifdef SERIALIZER_ZERO_PAD_EN
    last_idx = LEN_W'(DATA_W - 1);
`else
    last_idx = len_q - ONE;
`endif
    last_bit       = (state_q == SEND) && (cnt_q == last_idx);
    busy_o         = (state_q == SEND) && !last_bit;
    ser_data_val_o = (state_q == SEND);
`ifdef SERIALIZER_ZERO_PAD_EN
    // Bits past the captured length are forced to zero padding.
    ser_data_o = (state_q == SEND) && (cnt_q < len_q) && shift_q[0];
`else
    ser_data_o = (state_q == SEND) && shift_q[0];
`endif
    accept = data_val_i && !busy_o && (len_in >= MIN_LEN);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (accept) begin
      state_d = SEND;
      shift_d = data_i;
      cnt_d   = '0;
      len_d   = len_in;
    end else if (state_q == SEND) begin
      if (last_bit) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
        len_d   = '0;
      end else begin
        shift_d = {1'b0, shift_q[DATA_W-1:1]};
        cnt_d   = cnt_q + ONE;
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for the serializer, with a deserializer model on the serial side.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_n_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_val_i;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  // monitor-owned state
  int          val_cnt  = 0;
  int          run_len  = 0;
  int          last_run = 0;
  int          des_n    = 0;
  logic [15:0] des_w    = '0;
  logic [15:0] words_q[$];

`ifdef SERIALIZER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  serializer dut (
    .clk_i         (clk_i),
    .srst_n_i      (srst_n_i),
    .data_i        (data_i),
    .data_mod_i    (data_mod_i),
    .data_val_i    (data_val_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (ser_data_val_o) begin
      val_cnt++;
      run_len++;
      des_w[des_n] = ser_data_o;
      des_n++;
      if (des_n == 16) begin
        words_q.push_back(des_w);
        des_n = 0;
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      des_n   = 0;
    end
  end

  task automatic present(input logic [15:0] d, input logic [3:0] m);
    @(posedge clk_i); #1;
    data_i = d; data_mod_i = m; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] exp_w;
    srst_n_i = 1'b0; data_val_i = 1'b1; data_i = 16'hA5C3; data_mod_i = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({ser_data_val_o, ser_data_o, busy_o} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got val/data/busy=%b expected 000", i,
                 {ser_data_val_o, ser_data_o, busy_o});
      end
    end
    @(posedge clk_i); #1;
    srst_n_i = 1'b1; data_val_i = 1'b0;
    exp_w = 16'hA5C3;
    present(16'hA5C3, 4'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({ser_data_val_o, ser_data_o} !== {1'b1, exp_w[i]}) begin
        n_err++;
        $display("FAIL a5c3_bit%0d got val,data=%b expected %b", i,
                 {ser_data_val_o, ser_data_o}, {1'b1, exp_w[i]});
      end
    end
    @(negedge clk_i);
    n_cmp++;
    if (ser_data_val_o !== 1'b0) begin
      n_err++;
      $display("FAIL a5c3_end got val=%b expected 0", ser_data_val_o);
    end
  endtask

  task automatic test_partial;
    int          vlen;
    logic [1:0]  exp_vd;
    logic        exp_busy;
    vlen = PAD ? 16 : 5;
    present(16'h00FF, 4'd5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      exp_vd   = (i < vlen) ? {1'b1, (i < 5)} : 2'b00;
      exp_busy = (i < vlen - 1);
      n_cmp++;
      if ({ser_data_val_o, ser_data_o} !== exp_vd || busy_o !== exp_busy) begin
        n_err++;
        $display("FAIL partial_cyc%0d got val,data,busy=%b%b%b expected %b%b", i,
                 ser_data_val_o, ser_data_o, busy_o, exp_vd, exp_busy);
      end
    end
    n_cmp++;
    if (last_run != vlen) begin
      n_err++;
      $display("FAIL partial_len got %0d valid cycles expected %0d", last_run, vlen);
    end
  endtask

  task automatic test_ignored;
    for (int m = 1; m <= 2; m++) begin
      @(posedge clk_i); #1;
      data_i = 16'hFFFF; data_mod_i = 4'(m); data_val_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk_i);
        n_cmp++;
        if (ser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
          n_err++;
          $display("FAIL ignored_mod%0d got val=%b busy=%b expected 0 0", m,
                   ser_data_val_o, busy_o);
        end
      end
      data_val_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = words_q.size();
    @(posedge clk_i); #1;
    data_i = 16'h1234; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    data_i = 16'hFFFF;
    repeat (16) @(posedge clk_i);
    #1 data_val_i = 1'b0;
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (last_run != 32) begin
      n_err++;
      $display("FAIL b2b_run got %0d contiguous valid cycles expected 32", last_run);
    end
    n_cmp++;
    if (words_q.size() != base + 2) begin
      n_err++;
      $display("FAIL b2b_count got %0d frames expected 2", words_q.size() - base);
    end else begin
      n_cmp++;
      if (words_q[base] !== 16'h1234 || words_q[base+1] !== 16'hFFFF) begin
        n_err++;
        $display("FAIL b2b_words got %h %h expected 1234 ffff", words_q[base], words_q[base+1]);
      end
    end
  endtask

  task automatic test_busy_drop;
    int base;
    base = words_q.size();
    present(16'h0F0F, 4'd0);
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL drop_busy got busy=%b expected 1", busy_o);
    end
    @(posedge clk_i); #1;
    data_i = 16'hFFFF; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (last_run != 16 || words_q.size() != base + 1) begin
      n_err++;
      $display("FAIL drop_count got run=%0d frames=%0d expected 16 1", last_run,
               words_q.size() - base);
    end else begin
      n_cmp++;
      if (words_q[base] !== 16'h0F0F) begin
        n_err++;
        $display("FAIL drop_word got %h expected 0f0f", words_q[base]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int base_v;
    int base_w;
    present(16'hBEEF, 4'd0);
    repeat (7) @(posedge clk_i);
    #1 srst_n_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({ser_data_val_o, ser_data_o} !== 2'b11) begin
      n_err++;
      $display("FAIL mid_bit7 got val,data=%b expected 11", {ser_data_val_o, ser_data_o});
    end
    @(negedge clk_i);
    n_cmp++;
    if ({ser_data_val_o, ser_data_o, busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_abort got val/data/busy=%b expected 000",
               {ser_data_val_o, ser_data_o, busy_o});
    end
    @(posedge clk_i); #1;
    srst_n_i = 1'b1;
    base_v = val_cnt;
    base_w = words_q.size();
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (val_cnt != base_v || words_q.size() != base_w) begin
      n_err++;
      $display("FAIL mid_resume got %0d valid cycles %0d frames after release expected 0 0",
               val_cnt - base_v, words_q.size() - base_w);
    end
  endtask

  task automatic test_stream;
    int exp_run;
    exp_run = PAD ? 16 : 9;
    @(posedge clk_i); #1;
    data_i = 16'h0005; data_mod_i = 4'd3; data_val_i = 1'b1;
    @(posedge clk_i);
    repeat (8) @(posedge clk_i);
    #1 data_val_i = 1'b0;
    repeat (25) @(negedge clk_i);
    n_cmp++;
    if (last_run != exp_run) begin
      n_err++;
      $display("FAIL stream_run got %0d valid cycles expected %0d", last_run, exp_run);
    end
  endtask

  initial begin
    srst_n_i = 1'b0; data_i = '0; data_mod_i = '0; data_val_i = 1'b0;
    test_reset();
    test_partial();
    test_ignored();
    test_back_to_back();
    test_busy_drop();
    test_reset_mid();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial stage sitting directly upstream of the 16-bit deserializer. It accepts a parallel word plus a valid-bit count, then emits the bits one per clock on a single-bit data/valid pair that connects straight to the deserializer's serial input. Bit 0 goes out first, so the first received bit lands at index 0 downstream. A busy flag throttles the parallel source.

## Interface
Parameters:
- DATA_W, 16, parallel word width; must match the downstream deserializer.
- MOD_W, $clog2(DATA_W) = 4, width of the bit-count field.

Ports:
- clk_i  input  1  single clock; all logic on its rising edge.
- srst_n_i  input  1  synchronous reset, active-low.
- data_i  input  DATA_W  parallel word.
- data_mod_i  input  MOD_W  number of valid bits, starting at bit 0; value 0 means DATA_W.
- data_val_i  input  1  data_i/data_mod_i valid this cycle.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o valid.
- busy_o  output  1  block cannot accept a word this cycle.

## Operation
- Effective length: L = DATA_W if data_mod_i == 0, else data_mod_i.
- Words with L of 1 or 2 are discarded: nothing is transmitted and busy_o stays low.
- A word is accepted on a rising edge where data_val_i && !busy_o && L ≥ 3.
  - data_i is captured into a shift register; L is captured into a length register.
  - data_val_i while busy_o = 1 is ignored; the word is dropped, not queued.
- FSM has two states, IDLE and SEND:
  - IDLE → SEND on accept.
  - SEND → IDLE after the last bit if no new word is accepted that cycle.
  - SEND → SEND, reloading, if a new word is accepted during the last-bit cycle.
- In SEND:
  - ser_data_o = shift_reg[0]; the register shifts right one place per cycle.
  - A bit counter (MOD_W+1 bits) counts 0..L-1.
- busy_o = (state == SEND) && (bit_cnt != L-1). It is registered-state decode with no combinational path from inputs.
- ser_data_val_o = (state == SEND).
- ser_data_o is 0 whenever ser_data_val_o is 0.
- Reset values: ser_data_o = 0, ser_data_val_o = 0, busy_o = 0; FSM in IDLE; counter, length and shift register all 0.
- Reset asserted mid-word: the word is abandoned. All outputs are 0 on the cycle after the reset edge and no bits resume after deassertion.

## Timing
- Accept at edge k → ser_data_val_o high for cycles k+1 .. k+L.
  - ser_data_o carries data_i[i] in cycle k+1+i.
- Latency from accept to first bit: 1 cycle.
- busy_o is high in cycles k+1 .. k+L-1 and low in the last-bit cycle k+L.
  - A word presented in cycle k+L is accepted, and its bit 0 appears in cycle k+L+1.
  - Back-to-back words therefore stream with no idle gap, which the deserializer needs to see a contiguous 16-bit frame.
- IDLE with data_val_i held high: a new word is accepted every L cycles.

## Configuration
- SERIALIZER_ZERO_PAD_EN defined:
  - Any accepted word with L < DATA_W is followed by DATA_W - L zero bits, with ser_data_val_o kept high.
  - Every transmission is exactly DATA_W cycles, so each word completes one downstream frame.
  - busy_o drops in cycle k+DATA_W instead of k+L.
- SERIALIZER_ZERO_PAD_EN not defined: exactly L bits are sent, with timing as above.

## Structure
- Package serializer_pkg holds:
  - localparams DATA_W and MOD_W;
  - the state enum typedef (IDLE, SEND);
  - a function eff_len(mod) returning L.
- Single module with no sub-module; the shift register, counter and FSM are small enough to keep inline.

## Test plan
- Reset behaviour: srst_n_i low for 3 cycles with data_val_i = 1 → all outputs 0 and no transmission. Deassert, then present data_i = 16'hA5C3, mod = 0 → 16 valid bits in the order 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- Partial word: data_i = 16'h00FF, mod = 5 → 5 bits of 1, ser_data_val_o high exactly 5 cycles, busy_o high exactly 4 cycles. With SERIALIZER_ZERO_PAD_EN: 5 ones then 11 zeros, val high 16 cycles.
- Ignored lengths: mod = 1 and mod = 2 with data_val_i = 1 → ser_data_val_o stays 0 and busy_o stays 0.
- Back-to-back: 16'h1234 then 16'hFFFF, the second presented in the last-bit cycle → 32 contiguous valid cycles; a chained deserializer outputs 16'h1234 then 16'hFFFF.
- Busy drop: a second word presented mid-transmission with busy_o = 1 → it is ignored and only the first word appears on the serial output.
- Reset mid-word: srst_n_i low at bit 7 of 16'hBEEF → ser_data_val_o = 0 the next cycle, and after release the outputs stay idle until a new accept.
